// File: rtl/ldst_sequencer.sv
// ldst_sequencer: T-step control sequencer for ld / ldi / st instructions.
// Fetch (T0..T2), opcode decode (T3), then address and memory phases (T4..T7).
// The T1 and T6/T7 memory phases stretch by WAIT_STATES extra cycles. A 4-bit
// wait counter, cleared on every state entry, tracks position in a stretched step.
// Optional feature macro: LDST_SEQUENCER_STORE_EN enables the st instruction.
// When it is not defined, st decodes as illegal and RAMwrite is held at 0.
module ldst_sequencer #(
    parameter int                OPC_W       = 5,
    parameter int                WAIT_STATES = 0,
    parameter logic [OPC_W-1:0]  OP_LD       = 5'b00000,
    parameter logic [OPC_W-1:0]  OP_LDI      = 5'b00001,
    parameter logic [OPC_W-1:0]  OP_ST       = 5'b00010
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    output logic [19:0]      ctrl,
    output logic [2:0]       step,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    // ctrl bit positions
    localparam int C_PCOUT = 0,  C_MARIN = 1,  C_INCPC = 2,   C_ZLOWIN = 3;
    localparam int C_ZLOWOUT = 4, C_PCIN = 5,  C_MDMUXRD = 6, C_MDRIN = 7;
    localparam int C_MDROUT = 8, C_IRIN = 9,   C_GRA = 10,    C_GRB = 11;
    localparam int C_RIN = 12,   C_ROUT = 13,  C_BAOUT = 14,  C_YIN = 15;
    localparam int C_CSEOUT = 16, C_ADD = 17,  C_RAMRD = 18,  C_RAMWR = 19;

    localparam logic [3:0] LP_WLAST = 4'(WAIT_STATES);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
    } state_t;

    state_t           r_state, w_next;
    logic [3:0]       r_wait;
    logic [OPC_W-1:0] r_opc;
    logic             w_first, w_last, w_legal_in, w_st_en, w_is_st, w_is_ldi, w_end_st;

`ifdef LDST_SEQUENCER_STORE_EN
    assign w_st_en = 1'b1;
`else
    assign w_st_en = 1'b0;
`endif

    assign w_first    = (r_wait == 4'd0);
    assign w_last     = (r_wait == LP_WLAST);
    // Decode of the live opcode, only meaningful in T3
    assign w_legal_in = (opcode == OP_LD) || (opcode == OP_LDI) ||
                        (w_st_en && (opcode == OP_ST));
    assign w_is_st    = w_st_en && (r_opc == OP_ST);
    assign w_is_ldi   = (r_opc == OP_LDI);
    // Where the sequence goes after a done or illegal cycle: no bubble if run stays high
    assign w_end_st   = run ? S_T0 : S_IDLE;

    // State, wait counter and latched opcode; counter restarts on each state entry
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
            r_opc   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= 4'd0;
            else if (r_wait != 4'hF)
                r_wait <= r_wait + 4'd1;
            if (r_state == S_T3)
                r_opc <= opcode;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (run) w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   if (w_last) w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3:   w_next = w_legal_in ? S_T4 : state_t'(w_end_st);
            S_T4:   w_next = S_T5;
            S_T5:   w_next = w_is_ldi ? state_t'(w_end_st) : S_T6;
            S_T6:   if (w_is_st || w_last) w_next = S_T7;
            S_T7:   if (!w_is_st || w_last) w_next = state_t'(w_end_st);
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decode from state and wait counter (illegal looks at the live opcode in T3)
    always_comb begin
        ctrl    = '0;
        step    = 3'd0;
        busy    = (r_state != S_IDLE);
        done    = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_T0: begin
                step = 3'd0;
                ctrl[C_PCOUT] = 1'b1; ctrl[C_MARIN] = 1'b1;
                ctrl[C_INCPC] = 1'b1; ctrl[C_ZLOWIN] = 1'b1;
            end
            S_T1: begin
                step = 3'd1;
                ctrl[C_RAMRD]   = 1'b1; ctrl[C_MDMUXRD] = 1'b1;
                ctrl[C_ZLOWOUT] = w_first; ctrl[C_PCIN] = w_first;
                ctrl[C_MDRIN]   = w_last;
            end
            S_T2: begin
                step = 3'd2;
                ctrl[C_MDROUT] = 1'b1; ctrl[C_IRIN] = 1'b1;
            end
            S_T3: begin
                step = 3'd3;
                ctrl[C_GRB] = 1'b1; ctrl[C_BAOUT] = 1'b1; ctrl[C_YIN] = 1'b1;
                illegal = !w_legal_in;
            end
            S_T4: begin
                step = 3'd4;
                ctrl[C_CSEOUT] = 1'b1; ctrl[C_ADD] = 1'b1; ctrl[C_ZLOWIN] = 1'b1;
            end
            S_T5: begin
                step = 3'd5;
                ctrl[C_ZLOWOUT] = 1'b1;
                if (w_is_ldi) begin
                    ctrl[C_GRA] = 1'b1; ctrl[C_RIN] = 1'b1; done = 1'b1;
                end else begin
                    ctrl[C_MARIN] = 1'b1;
                end
            end
            S_T6: begin
                step = 3'd6;
                if (w_is_st) begin
                    // Register value goes to MDR through the non-memory mux leg
                    ctrl[C_GRA] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_MDRIN] = 1'b1;
                end else begin
                    ctrl[C_RAMRD] = 1'b1; ctrl[C_MDMUXRD] = 1'b1;
                    ctrl[C_MDRIN] = w_last;
                end
            end
            S_T7: begin
                step = 3'd7;
                ctrl[C_MDROUT] = 1'b1;
                if (w_is_st) begin
                    ctrl[C_RAMWR] = w_st_en; done = w_last;
                end else begin
                    ctrl[C_GRA] = 1'b1; ctrl[C_RIN] = 1'b1; done = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ldst_sequencer.sv
// Directed bench for ldst_sequencer: four instances with WAIT_STATES 0..3.
module tb_ldst_sequencer;
    // Hand-derived ctrl words
    localparam logic [19:0] C_IDLE  = 20'h00000;
    localparam logic [19:0] C_T0    = 20'h0000F; // PCout MARin IncPC Zlowin
    localparam logic [19:0] C_T1_FL = 20'h400F0; // RAMread MDMux Zlowout PCin MDRin
    localparam logic [19:0] C_T1_F  = 20'h40070; // first of several
    localparam logic [19:0] C_RDMID = 20'h40040; // RAMread MDMux only
    localparam logic [19:0] C_RDLST = 20'h400C0; // RAMread MDMux MDRin
    localparam logic [19:0] C_T2    = 20'h00300; // MDRout IRin
    localparam logic [19:0] C_T3    = 20'h0C800; // Grb BAout Yin
    localparam logic [19:0] C_T4    = 20'h30008; // CSEout ADD Zlowin
    localparam logic [19:0] C_T5    = 20'h00012; // Zlowout MARin
    localparam logic [19:0] C_T5I   = 20'h01410; // Zlowout Gra Rin
    localparam logic [19:0] C_T6S   = 20'h02480; // Gra Rout MDRin
    localparam logic [19:0] C_T7L   = 20'h01500; // MDRout Gra Rin
    localparam logic [19:0] C_T7S   = 20'h80100; // MDRout RAMwrite

    logic        clk = 1'b0;
    logic [3:0]  clr, rn;
    logic [4:0]  opc [4];
    logic [19:0] ctrl_o [4];
    logic [2:0]  step_o [4];
    logic [3:0]  busy_o, done_o, ill_o;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ldst_sequencer #(.WAIT_STATES(0)) u0 (.clock(clk), .clear(clr[0]), .run(rn[0]), .opcode(opc[0]),
        .ctrl(ctrl_o[0]), .step(step_o[0]), .busy(busy_o[0]), .done(done_o[0]), .illegal(ill_o[0]));
    ldst_sequencer #(.WAIT_STATES(1)) u1 (.clock(clk), .clear(clr[1]), .run(rn[1]), .opcode(opc[1]),
        .ctrl(ctrl_o[1]), .step(step_o[1]), .busy(busy_o[1]), .done(done_o[1]), .illegal(ill_o[1]));
    ldst_sequencer #(.WAIT_STATES(2)) u2 (.clock(clk), .clear(clr[2]), .run(rn[2]), .opcode(opc[2]),
        .ctrl(ctrl_o[2]), .step(step_o[2]), .busy(busy_o[2]), .done(done_o[2]), .illegal(ill_o[2]));
    ldst_sequencer #(.WAIT_STATES(3)) u3 (.clock(clk), .clear(clr[3]), .run(rn[3]), .opcode(opc[3]),
        .ctrl(ctrl_o[3]), .step(step_o[3]), .busy(busy_o[3]), .done(done_o[3]), .illegal(ill_o[3]));

    // Compare {ctrl,step,busy,done,illegal} of instance k
    task automatic chk(input string tag, input int k, input logic [19:0] c, input logic [2:0] s,
                       input logic b, input logic d, input logic il);
        logic [25:0] got, exp;
        got = {ctrl_o[k], step_o[k], busy_o[k], done_o[k], ill_o[k]};
        exp = {c, s, b, d, il};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s inst%0d got ctrl=%h step=%0d busy=%b done=%b ill=%b exp ctrl=%h step=%0d busy=%b done=%b ill=%b",
                   tag, k, got[25:6], got[5:3], got[2], got[1], got[0], c, s, b, d, il);
        end
    endtask

    // Advance one clock, then compare
    task automatic cyc(input string tag, input int k, input logic [19:0] c, input logic [2:0] s,
                       input logic b, input logic d, input logic il);
        @(posedge clk); #1;
        chk(tag, k, c, s, b, d, il);
    endtask

    // Common fetch/decode head for instance k with WAIT_STATES w (T0..T2)
    task automatic fetch(input string tag, input int k, input int w);
        cyc({tag, "_T0"}, k, C_T0, 3'd0, 1, 0, 0);
        if (w == 0) cyc({tag, "_T1"}, k, C_T1_FL, 3'd1, 1, 0, 0);
        else begin
            cyc({tag, "_T1a"}, k, C_T1_F, 3'd1, 1, 0, 0);
            for (int i = 1; i < w; i++) cyc({tag, "_T1m"}, k, C_RDMID, 3'd1, 1, 0, 0);
            cyc({tag, "_T1z"}, k, C_RDLST, 3'd1, 1, 0, 0);
        end
        cyc({tag, "_T2"}, k, C_T2, 3'd2, 1, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 4'hF; rn = 4'h0;
        for (int i = 0; i < 4; i++) opc[i] = 5'b00000;
        // Reset: run held high too, clear must win
        rn = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 4; i++) chk("reset", i, C_IDLE, 3'd0, 0, 0, 0);
        rn = 4'h0; clr = 4'h0;
        cyc("idle_hold", 0, C_IDLE, 3'd0, 0, 0, 0);

        // W=0 ld with run held: T0..T7, done in cycle 8, then straight to T0
        rn[0] = 1; opc[0] = 5'b00000;
        fetch("ld0", 0, 0);
        cyc("ld0_T3", 0, C_T3, 3'd3, 1, 0, 0);
        cyc("ld0_T4", 0, C_T4, 3'd4, 1, 0, 0);
        cyc("ld0_T5", 0, C_T5, 3'd5, 1, 0, 0);
        cyc("ld0_T6", 0, C_RDLST, 3'd6, 1, 0, 0);
        cyc("ld0_T7", 0, C_T7L, 3'd7, 1, 1, 0);
        // Back-to-back: next instruction is ldi, run dropped mid-instruction
        cyc("b2b_T0", 0, C_T0, 3'd0, 1, 0, 0);
        rn[0] = 0; opc[0] = 5'b00001;
        cyc("ldi0_T1", 0, C_T1_FL, 3'd1, 1, 0, 0);
        cyc("ldi0_T2", 0, C_T2, 3'd2, 1, 0, 0);
        cyc("ldi0_T3", 0, C_T3, 3'd3, 1, 0, 0);
        cyc("ldi0_T4", 0, C_T4, 3'd4, 1, 0, 0);
        cyc("ldi0_T5", 0, C_T5I, 3'd5, 1, 1, 0);
        cyc("ldi0_idle", 0, C_IDLE, 3'd0, 0, 0, 0);

        // Illegal opcode, run low at decode -> IDLE
        rn[0] = 1; opc[0] = 5'b11111;
        cyc("ill_T0", 0, C_T0, 3'd0, 1, 0, 0);
        rn[0] = 0;
        cyc("ill_T1", 0, C_T1_FL, 3'd1, 1, 0, 0);
        cyc("ill_T2", 0, C_T2, 3'd2, 1, 0, 0);
        cyc("ill_T3", 0, C_T3, 3'd3, 1, 0, 1);
        cyc("ill_idle", 0, C_IDLE, 3'd0, 0, 0, 0);

        // W=1 st
        rn[1] = 1; opc[1] = 5'b00010;
        fetch("st1", 1, 1);
        rn[1] = 0;
`ifdef LDST_SEQUENCER_STORE_EN
        cyc("st1_T3", 1, C_T3, 3'd3, 1, 0, 0);
        cyc("st1_T4", 1, C_T4, 3'd4, 1, 0, 0);
        cyc("st1_T5", 1, C_T5, 3'd5, 1, 0, 0);
        cyc("st1_T6", 1, C_T6S, 3'd6, 1, 0, 0);
        cyc("st1_T7a", 1, C_T7S, 3'd7, 1, 0, 0);
        cyc("st1_T7b", 1, C_T7S, 3'd7, 1, 1, 0);
`else
        cyc("st1_ill", 1, C_T3, 3'd3, 1, 0, 1);
`endif
        cyc("st1_idle", 1, C_IDLE, 3'd0, 0, 0, 0);

        // W=2 ld: T1 and T6 three cycles each, done at cycle 12
        rn[2] = 1; opc[2] = 5'b00000;
        fetch("ld2", 2, 2);
        rn[2] = 0;
        cyc("ld2_T3", 2, C_T3, 3'd3, 1, 0, 0);
        cyc("ld2_T4", 2, C_T4, 3'd4, 1, 0, 0);
        cyc("ld2_T5", 2, C_T5, 3'd5, 1, 0, 0);
        cyc("ld2_T6a", 2, C_RDMID, 3'd6, 1, 0, 0);
        cyc("ld2_T6b", 2, C_RDMID, 3'd6, 1, 0, 0);
        cyc("ld2_T6c", 2, C_RDLST, 3'd6, 1, 0, 0);
        cyc("ld2_T7", 2, C_T7L, 3'd7, 1, 1, 0);
        cyc("ld2_idle", 2, C_IDLE, 3'd0, 0, 0, 0);

        // W=3 ld aborted by clear in the T6 wait, then a clean ldi
        rn[3] = 1; opc[3] = 5'b00000;
        fetch("ld3", 3, 3);
        rn[3] = 0;
        cyc("ld3_T3", 3, C_T3, 3'd3, 1, 0, 0);
        cyc("ld3_T4", 3, C_T4, 3'd4, 1, 0, 0);
        cyc("ld3_T5", 3, C_T5, 3'd5, 1, 0, 0);
        cyc("ld3_T6a", 3, C_RDMID, 3'd6, 1, 0, 0);
        cyc("ld3_T6b", 3, C_RDMID, 3'd6, 1, 0, 0);
        clr[3] = 1; rn[3] = 1;
        cyc("clr3", 3, C_IDLE, 3'd0, 0, 0, 0);
        clr[3] = 0; opc[3] = 5'b00001;
        fetch("ldi3", 3, 3);
        rn[3] = 0;
        cyc("ldi3_T3", 3, C_T3, 3'd3, 1, 0, 0);
        cyc("ldi3_T4", 3, C_T4, 3'd4, 1, 0, 0);
        cyc("ldi3_T5", 3, C_T5I, 3'd5, 1, 1, 0);
        cyc("ldi3_idle", 3, C_IDLE, 3'd0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ldst_sequencer.md
LDST_SEQUENCER -- requirements
Module: ldst_sequencer

Interface
- REQ-001 Parameter OPC_W, default 5, opcode field width.
- REQ-002 Parameter WAIT_STATES, default 0, extra RAM cycles per memory access, legal range 0..15.
- REQ-003 Parameter OP_LD, default 5'b00000, ld opcode.
- REQ-004 Parameter OP_LDI, default 5'b00001, ldi opcode.
- REQ-005 Parameter OP_ST, default 5'b00010, st opcode.
- REQ-006 clock  in  1  sole clock; all state updates on its rising edge.
- REQ-007 clear  in  1  reset, synchronous, active-high.
- REQ-008 run  in  1  level; permits instruction fetch to start.
- REQ-009 opcode  in  OPC_W  IR[31:27] from the datapath; sampled in T3 only.
- REQ-010 ctrl  out  20  control strobes to Datapath. Bit map: 0 PCout, 1 MARin, 2 IncPC, 3 Zlowin, 4 Zlowout, 5 PCin, 6 MDMuxRead, 7 MDRin, 8 MDRout, 9 IRin, 10 Gra, 11 Grb, 12 Rin, 13 Rout, 14 BAout, 15 Yin, 16 CSEout, 17 ADD, 18 RAMread, 19 RAMwrite.
- REQ-011 step  out  3  current T-step number, 0..7.
- REQ-012 busy  out  1  high in every state except IDLE.
- REQ-013 done  out  1  one-cycle pulse in the final step of a completed instruction.
- REQ-014 illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.

Function
- REQ-015 States: IDLE, T0..T7, plus a wait counter of 4 bits. Outputs are Moore-decoded from the current state and the wait counter.
- REQ-016 IDLE: ctrl=0, step=0, busy=0. The block SHALL go to T0 when run=1.
- REQ-017 T0: PCout, MARin, IncPC, Zlowin -> T1.
- REQ-018 T1 (memory read): Zlowout, PCin, RAMread, MDMuxRead, held for WAIT_STATES+1 cycles.
  - PCin and Zlowout SHALL be asserted in the first cycle only.
  - MDRin SHALL be asserted in the last cycle only.
  - Next state T2.
- REQ-019 T2: MDRout, IRin -> T3.
- REQ-020 T3: Grb, BAout, Yin. The opcode is latched here.
  - ld, ldi and st go to T4.
  - Any other opcode asserts illegal and goes to IDLE if run=0, otherwise to T0.
- REQ-021 T4: CSEout, ADD, Zlowin -> T5.
- REQ-022 T5:
  - ld and st: Zlowout, MARin -> T6.
  - ldi: Zlowout, Gra, Rin, done; then ends (see REQ-026).
- REQ-023 T6:
  - ld: RAMread and MDMuxRead for WAIT_STATES+1 cycles, with MDRin in the last cycle -> T7.
  - st: Gra, Rout, MDRin, with MDMuxRead=0, for one cycle -> T7.
- REQ-024 T7:
  - ld: MDRout, Gra, Rin, done, for one cycle.
  - st: MDRout and RAMwrite for WAIT_STATES+1 cycles, with done in the last cycle.
- REQ-025 Latency with W=WAIT_STATES:
  - ld: 8+2W cycles.
  - st: 8+2W cycles.
  - ldi: 6+W cycles.
  - illegal: 4+W cycles.
- REQ-026 End of instruction: after the done or illegal cycle, go to T0 if run=1, else to IDLE. There SHALL be no idle bubble between back-to-back instructions.
- REQ-027 Deasserting run mid-instruction SHALL NOT abort the instruction. run is sampled only in IDLE and at instruction end.
- REQ-028 The wait counter SHALL reset to 0 on every state entry. It SHALL saturate and never wrap.
- REQ-029 RAMread and RAMwrite SHALL never be high in the same cycle. PCin and MARin SHALL never be high in the same cycle.

Reset
- REQ-030 clear=1 at a clock edge forces the following state:
  - state IDLE, wait counter 0, latched opcode 0;
  - ctrl=0, step=0, busy=0, done=0, illegal=0.
- REQ-031 clear takes priority over run and over any in-flight step, including mid-wait. The block SHALL restart from IDLE.

Configuration
- REQ-032 Macro LDST_SEQUENCER_STORE_EN:
  - Defined: st is executed per REQ-022 to REQ-024.
  - Undefined: OP_ST is treated as illegal per REQ-020, and RAMwrite is tied to 0.

Verification
- REQ-033 W=0, run=1, opcode=OP_LD (ld R2,0x95) -> steps T0..T7 in 8 cycles, ctrl matches REQ-017 to REQ-024 each cycle, done in cycle 8, then T0.
- REQ-034 W=2, ld -> T1 and T6 each last 3 cycles, MDRin only in their third cycle, done at cycle 12.
- REQ-035 W=0, opcode=OP_LDI -> done at cycle 6 with Gra, Rin and Zlowout; no RAMread after T1.
- REQ-036 W=1, macro defined, opcode=OP_ST -> T7 RAMwrite for 2 cycles, done at cycle 10. Macro undefined -> illegal pulse at cycle 5 (T3), RAMwrite never high.
- REQ-037 opcode=5'b11111 -> illegal in T3. With run=0 -> IDLE next cycle, busy=0.
- REQ-038 clear asserted during the T6 wait (W=3) -> next cycle IDLE, ctrl=0. The next instruction with run=1 completes normally.
